// File: rtl/sync_peak_det_pkg.sv
// Shared constants and FSM encoding for the preamble sync decision stage.
package sync_peak_det_pkg;

  localparam int unsigned SYNC_P_W       = 23;
  localparam int unsigned SYNC_R_W       = 23;
  localparam int unsigned SYNC_THR       = 6;
  localparam int unsigned SYNC_MIN_RUN   = 16;
  localparam int unsigned SYNC_MAX_RUN   = 64;
  localparam int unsigned SYNC_HOLDOFF   = 320;
  localparam int unsigned SYNC_CNT_W     = 9;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    QUAL   = 2'd1,
    PLAT   = 2'd2,
    HOLD   = 2'd3
  } sync_state_e;

  function automatic int unsigned sync_max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_metric_cmp.sv
// Stage 1: clamp negative energy to zero, compare 8*P against THR*R, register hit and P.
module sync_metric_cmp
  import sync_peak_det_pkg::*;
#(
  parameter int unsigned P_W = SYNC_P_W,
  parameter int unsigned R_W = SYNC_R_W,
  parameter int unsigned THR = SYNC_THR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ena,
  input  logic [P_W-1:0]        i_p_mag,
  input  logic signed [R_W-1:0] i_r_sum,
  output logic                  o_hit_q,
  output logic [P_W-1:0]        o_p_q
);

  // Four guard bits cover the x8 on P and THR (< 16) on R.
  localparam int unsigned CMP_W = sync_max_w(P_W, R_W) + 4;

  logic [R_W-1:0]   w_r_pos;
  logic [CMP_W-1:0] w_lhs;
  logic [CMP_W-1:0] w_rhs;
  logic             w_hit;

  // Clamp, scale and compare; zero energy never produces a hit.
  always_comb begin
    w_r_pos = i_r_sum[R_W-1] ? '0 : $unsigned(i_r_sum);
    w_lhs   = CMP_W'({i_p_mag, 3'b000});
    w_rhs   = CMP_W'(w_r_pos) * CMP_W'(THR);
    w_hit   = (w_lhs > w_rhs) && (w_r_pos != '0);
  end

  // Pipeline register, advancing only on enabled samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_hit_q <= 1'b0;
      o_p_q   <= '0;
    end else if (i_ena) begin
      o_hit_q <= w_hit;
      o_p_q   <= i_p_mag;
    end
  end

endmodule

// File: rtl/sync_peak_det.sv
// Plateau qualifier and peak locator: emits one detection pulse per plateau, then blanks.
module sync_peak_det
  import sync_peak_det_pkg::*;
#(
  parameter int unsigned P_W     = SYNC_P_W,
  parameter int unsigned R_W     = SYNC_R_W,
  parameter int unsigned THR     = SYNC_THR,
  parameter int unsigned MIN_RUN = SYNC_MIN_RUN,
  parameter int unsigned MAX_RUN = SYNC_MAX_RUN,
  parameter int unsigned HOLDOFF = SYNC_HOLDOFF,
  parameter int unsigned CNT_W   = SYNC_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [P_W-1:0]        p_mag,
  input  logic signed [R_W-1:0] r_sum,
  output logic                  det_pulse,
  output logic [P_W-1:0]        det_peak,
  output logic [CNT_W-1:0]      det_offset,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  sync_state_e      r_state;
  sync_state_e      w_state_nxt;
  logic             w_hit_q;
  logic [P_W-1:0]   w_p_q;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_age;
  logic [CNT_W-1:0] r_hold;
  logic [P_W-1:0]   r_max;
  logic             r_det_pulse;
  logic [P_W-1:0]   r_det_peak;
  logic [CNT_W-1:0] r_det_offset;

  logic             w_new_max;
  logic [P_W-1:0]   w_max_nxt;
  logic [CNT_W-1:0] w_age_inc;
  logic [CNT_W-1:0] w_age_nxt;
  logic [CNT_W-1:0] w_run_inc;
  logic             w_term;

  sync_metric_cmp #(
    .P_W (P_W),
    .R_W (R_W),
    .THR (THR)
  ) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .i_ena   (ena),
    .i_p_mag (p_mag),
    .i_r_sum (r_sum),
    .o_hit_q (w_hit_q),
    .o_p_q   (w_p_q)
  );

  // Max/age tracking and plateau termination terms.
  always_comb begin
    w_new_max = w_p_q > r_max;
    w_max_nxt = w_new_max ? w_p_q : r_max;
    w_age_inc = r_age + ONE;
    w_age_nxt = w_new_max ? '0 : w_age_inc;
    w_run_inc = r_run + ONE;
    w_term    = (r_state == PLAT) && (!w_hit_q || (w_run_inc == CNT_W'(MAX_RUN)));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode, only on enabled samples.
  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      case (r_state)
        SEARCH: if (w_hit_q) w_state_nxt = QUAL;
        QUAL: begin
          if (!w_hit_q)                           w_state_nxt = SEARCH;
          else if (w_run_inc == CNT_W'(MIN_RUN)) w_state_nxt = PLAT;
        end
        PLAT:    if (w_term) w_state_nxt = HOLD;
        HOLD:    if (r_hold <= ONE) w_state_nxt = SEARCH;
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  // Counters, running max and detection result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run        <= '0;
      r_age        <= '0;
      r_hold       <= '0;
      r_max        <= '0;
      r_det_pulse  <= 1'b0;
      r_det_peak   <= '0;
      r_det_offset <= '0;
    end else begin
      r_det_pulse <= 1'b0;
      if (ena) begin
        case (r_state)
          SEARCH: begin
            if (w_hit_q) begin
              r_run <= ONE;
              r_max <= w_p_q;
              r_age <= '0;
            end
          end
          QUAL: begin
            if (w_hit_q) begin
              r_run <= w_run_inc;
              r_max <= w_max_nxt;
              r_age <= w_age_nxt;
            end else begin
              r_run <= '0;
              r_max <= '0;
              r_age <= '0;
            end
          end
          PLAT: begin
            if (w_term) begin
              // A terminating hit still takes part in max tracking; a miss only ages the peak.
              r_det_pulse  <= 1'b1;
              r_det_peak   <= w_hit_q ? w_max_nxt : r_max;
              r_det_offset <= w_hit_q ? w_age_nxt : w_age_inc;
              r_hold       <= CNT_W'(HOLDOFF);
              r_run        <= '0;
              r_max        <= '0;
              r_age        <= '0;
            end else begin
              r_run <= w_run_inc;
              r_max <= w_max_nxt;
              r_age <= w_age_nxt;
            end
          end
          HOLD:    r_hold <= r_hold - ONE;
          default: r_hold <= '0;
        endcase
      end
    end
  end

  // Outputs.
  always_comb begin
    busy       = (r_state != SEARCH);
    det_pulse  = r_det_pulse;
    det_peak   = r_det_peak;
    det_offset = r_det_offset;
  end

endmodule

// File: tb/tb_sync_peak_det.sv
// Directed bench for sync_peak_det with hand-computed expectations (r_sum=1000 => hit iff p_mag>750).
module tb_sync_peak_det;

  logic               clk;
  logic               rst;
  logic               ena;
  logic [22:0]        p_mag;
  logic signed [22:0] r_sum;
  logic               det_pulse;
  logic [22:0]        det_peak;
  logic [8:0]         det_offset;
  logic               busy;

  int checks = 0;
  int passed = 0;

  sync_peak_det #(
    .P_W     (23),
    .R_W     (23),
    .THR     (6),
    .MIN_RUN (16),
    .MAX_RUN (64),
    .HOLDOFF (320),
    .CNT_W   (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .p_mag      (p_mag),
    .r_sum      (r_sum),
    .det_pulse  (det_pulse),
    .det_peak   (det_peak),
    .det_offset (det_offset),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One enabled sample; outputs afterwards reflect the FSM decision on the previous sample.
  task automatic step(input logic [22:0] p, input logic signed [22:0] r);
    p_mag = p;
    r_sum = r;
    ena   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    p_mag = '0;
    r_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
    checks++; if (det_pulse !== 1'b0) $display("FAIL reset_pulse got=%0b exp=0", det_pulse); else passed++;
    checks++; if (det_peak !== 23'd0) $display("FAIL reset_peak got=%0d exp=0", det_peak); else passed++;
    checks++; if (det_offset !== 9'd0) $display("FAIL reset_offset got=%0d exp=0", det_offset); else passed++;
  endtask

  task automatic test_threshold();
    step(23'd800, 23'sd1000);
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b1) $display("FAIL thr_800_hit busy got=%0b exp=1", busy); else passed++;
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b0) $display("FAIL thr_miss_back busy got=%0b exp=0", busy); else passed++;
    step(23'd750, 23'sd1000);
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b0) $display("FAIL thr_750_equal busy got=%0b exp=0", busy); else passed++;
    step(23'd751, 23'sd1000);
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b1) $display("FAIL thr_751_hit busy got=%0b exp=1", busy); else passed++;
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b0) $display("FAIL thr_751_back busy got=%0b exp=0", busy); else passed++;
  endtask

  task automatic test_negative();
    step(23'd1, -23'sd5);
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b0) $display("FAIL neg_small busy got=%0b exp=0", busy); else passed++;
    step(23'd5000000, -23'sd5);
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b0) $display("FAIL neg_bigp busy got=%0b exp=0", busy); else passed++;
    step(23'd5000, 23'sd0);
    step(23'd100, 23'sd1000);
    checks++; if (busy !== 1'b0) $display("FAIL zero_r busy got=%0b exp=0", busy); else passed++;
    checks++; if (det_pulse !== 1'b0) $display("FAIL neg_pulse got=%0b exp=0", det_pulse); else passed++;
  endtask

  task automatic test_false_alarm();
    logic exp_busy;
    for (int i = 1; i <= 12; i++) begin
      step((i <= 10) ? 23'd800 : 23'd100, 23'sd1000);
      exp_busy = (i >= 2) && (i <= 11);
      checks++; if (busy !== exp_busy) $display("FAIL fa_busy i=%0d got=%0b exp=%0b", i, busy, exp_busy); else passed++;
      checks++; if (det_pulse !== 1'b0) $display("FAIL fa_pulse i=%0d got=%0b exp=0", i, det_pulse); else passed++;
    end
  endtask

  task automatic test_normal();
    logic [22:0] pv;
    for (int i = 1; i <= 23; i++) begin
      if (i <= 20) pv = (i == 14) ? 23'd5000 : 23'd800;
      else         pv = 23'd100;
      step(pv, 23'sd1000);
      checks++; if (det_pulse !== (i == 22)) $display("FAIL norm_pulse i=%0d got=%0b exp=%0b", i, det_pulse, (i == 22)); else passed++;
      if (i >= 22) begin
        checks++; if (busy !== 1'b1) $display("FAIL norm_hold_busy i=%0d got=%0b exp=1", i, busy); else passed++;
        checks++; if (det_peak !== 23'd5000) $display("FAIL norm_peak i=%0d got=%0d exp=5000", i, det_peak); else passed++;
        checks++; if (det_offset !== 9'd7) $display("FAIL norm_offset i=%0d got=%0d exp=7", i, det_offset); else passed++;
      end
    end
  endtask

  task automatic test_max_run();
    logic [22:0] pv;
    logic        exp_busy;
    do_reset();
    for (int i = 1; i <= 387; i++) begin
      if (i <= 64)       pv = 23'(1000 + i);
      else if (i <= 385) pv = 23'd800;
      else               pv = 23'd100;
      step(pv, 23'sd1000);
      exp_busy = (i >= 2 && i <= 384) || (i == 386);
      checks++; if (busy !== exp_busy) $display("FAIL max_busy i=%0d got=%0b exp=%0b", i, busy, exp_busy); else passed++;
      checks++; if (det_pulse !== (i == 65)) $display("FAIL max_pulse i=%0d got=%0b exp=%0b", i, det_pulse, (i == 65)); else passed++;
      if (i == 65 || i == 387) begin
        checks++; if (det_peak !== 23'd1064) $display("FAIL max_peak i=%0d got=%0d exp=1064", i, det_peak); else passed++;
        checks++; if (det_offset !== 9'd0) $display("FAIL max_offset i=%0d got=%0d exp=0", i, det_offset); else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 30; i++) step(23'd800, 23'sd1000);
    checks++; if (busy !== 1'b1) $display("FAIL arst_pre_busy got=%0b exp=1", busy); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL arst_busy got=%0b exp=0", busy); else passed++;
    checks++; if (det_peak !== 23'd0) $display("FAIL arst_peak got=%0d exp=0", det_peak); else passed++;
    checks++; if (det_offset !== 9'd0) $display("FAIL arst_offset got=%0d exp=0", det_offset); else passed++;
    checks++; if (det_pulse !== 1'b0) $display("FAIL arst_pulse got=%0b exp=0", det_pulse); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(23'd100, 23'sd1000);
      checks++; if (det_pulse !== 1'b0) $display("FAIL arst_after_pulse i=%0d got=%0b exp=0", i, det_pulse); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL arst_after_busy i=%0d got=%0b exp=0", i, busy); else passed++;
    end
  endtask

  task automatic test_ena_gap();
    logic [22:0] pv;
    for (int g = 0; g < 2; g++) begin
      do_reset();
      for (int i = 1; i <= 28; i++) begin
        if (i <= 25) pv = (i == 12) ? 23'd3000 : 23'd800;
        else         pv = 23'd100;
        step(pv, 23'sd1000);
        checks++; if (det_pulse !== (i == 27)) $display("FAIL gap%0d_pulse i=%0d got=%0b exp=%0b", g, i, det_pulse, (i == 27)); else passed++;
        if (g == 1 && i == 18) begin
          ena   = 1'b0;
          p_mag = 23'd100;
          for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++; if (busy !== 1'b1) $display("FAIL gap_busy k=%0d got=%0b exp=1", k, busy); else passed++;
            checks++; if (det_pulse !== 1'b0) $display("FAIL gap_pulse k=%0d got=%0b exp=0", k, det_pulse); else passed++;
          end
        end
        if (i == 27) begin
          checks++; if (det_peak !== 23'd3000) $display("FAIL gap%0d_peak got=%0d exp=3000", g, det_peak); else passed++;
          checks++; if (det_offset !== 9'd14) $display("FAIL gap%0d_offset got=%0d exp=14", g, det_offset); else passed++;
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    p_mag = '0;
    r_sum = '0;
    test_reset();
    test_threshold();
    test_negative();
    test_false_alarm();
    test_normal();
    test_max_run();
    test_async_reset();
    test_ena_gap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sync_peak_det.md
Name: sync_peak_det

Overview:
Frame-timing decision stage directly downstream of the R energy moving-sum accumulator in the 802.16 RX preamble synchroniser. Per enabled sample, it compares the autocorrelation magnitude P against a programmable fraction of the energy sum R. It qualifies a sustained plateau of hits and locates the P maximum inside it. It emits a single detection pulse carrying the peak value and its age, then blanks for a hold-off window.

Parameters:
P_W, 23, width of unsigned p_mag input
R_W, 23, width of signed r_sum input (matches the accumulator's sum_out)
THR, 6, threshold numerator in eighths; a hit requires p > (THR/8)*r
MIN_RUN, 16, consecutive hits required to qualify a plateau
MAX_RUN, 64, plateau length that forces termination
HOLDOFF, 320, enabled samples blanked after a detection
CNT_W, 9, width of the run, age and hold counters (must hold HOLDOFF and MAX_RUN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ena  in  1  sample strobe; all state advances only when high
p_mag  in  P_W  unsigned autocorrelation magnitude, aligned with r_sum
r_sum  in  R_W  signed moving energy sum (accumulator sum_out)
det_pulse  out  1  one-clk detection strobe
det_peak  out  P_W  maximum p_mag within the detected plateau
det_offset  out  CNT_W  enabled samples after the peak, up to and including the terminating sample
busy  out  1  high in QUAL, PLAT or HOLD

Behaviour:
- Reset is asynchronous. The clk and rst naming and the async active-high reset are fixed. On reset: FSM=SEARCH, all counters 0, det_pulse=0, det_peak=0, det_offset=0, busy=0.
- Stage 1 (registered on ena): r_pos = r_sum<0 ? 0 : r_sum.
  - hit_q <= ({p_mag,3'b000} > r_pos*THR) && (r_pos != 0).
  - The compare is unsigned, with both sides extended to max(P_W,R_W)+4 bits so no overflow occurs.
  - p_q <= p_mag.
- FSM (evaluated on ena cycles using hit_q/p_q; total latency input→det_pulse = 2 clk at back-to-back ena):
  - SEARCH: hit_q → QUAL, run=1, max=p_q, age=0.
  - QUAL: on hit_q, run++ and track the max; when run reaches MIN_RUN → PLAT. On !hit_q → SEARCH and clear run/max/age (false alarm, no pulse).
  - PLAT: on hit_q, track the max and run++. Terminate on !hit_q, or on the hit where run reaches MAX_RUN. Termination sets det_pulse=1 for one clk, det_peak=max, det_offset=age, then → HOLD with hold=HOLDOFF.
  - HOLD: hold-- per ena; the state ends after HOLDOFF enabled samples → SEARCH. hit_q is ignored throughout.
- Max tracking: if p_q > max (strict), max<=p_q and age<=0, else age++. Ties keep the earliest sample. The terminating !hit sample increments age.
- det_peak and det_offset hold their value until the next detection. det_pulse is 0 whenever ena is low.
- ena low: every register holds, including the stage-1 pipeline.
- Reset during QUAL or PLAT aborts without a pulse.

Decomposition:
- Shared sync package/header: FSM state encodings (SEARCH, QUAL, PLAT, HOLD), default widths, and THR/MIN_RUN/MAX_RUN/HOLDOFF constants shared with the P correlator stage.
- One sub-module: sync_metric_cmp (stage-1 clamp, scale, compare, p_q register).

Test Plan:
- Threshold edge, r_sum=1000 constant: p_mag=800 → hit_q=1 (6400>6000). p_mag=750 → hit_q=0 (equality is not a hit).
- Negative energy, r_sum=-5 and p_mag=1 → hit_q=0, FSM stays in SEARCH, busy=0.
- False alarm: 10 hits then a miss → no det_pulse, FSM returns to SEARCH, busy drops on the clk after the miss.
- Normal detection: 20 hits with the peak 5000 at hit #14, miss at #21 → one det_pulse, det_peak=5000, det_offset=7, busy stays 1 (HOLD).
- MAX_RUN: 64 continuous rising hits, peak at #64 → det_pulse on #64, det_offset=0. Hits during the next 320 enabled samples are ignored. A hit at enabled sample 321 after the pulse enters QUAL.
- Async rst asserted mid-PLAT (hit #30), plus ena toggled low for 5 clk mid-plateau: rst clears everything immediately with no pulse. The ena gap produces an identical det_offset to the gap-free run.
